// File: rtl/rv32_arb_pkg.sv
// Shared constants and types for the data-memory arbiter.
package rv32_arb_pkg;

  localparam int MAX_WAIT_DEF = 4;
  localparam int MEMI_W       = 3;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive denied host cycles.
module dmem_arb_starve_cnt
  import rv32_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic reached_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // High when one more increment brings the count to MAX_WAIT; independent of
  // inc_i so the FSM can use it without a combinational loop.
  assign reached_o = (cnt_q >= (LIMIT - CNT_W'(1)));

  // Next count: clear wins, otherwise increment up to LIMIT and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host data-memory arbiter: core has priority, host is guaranteed a
// forced slot after MAX_WAIT consecutive denied cycles.
module dmem_arbiter
  import rv32_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [MEMI_W-1:0] core_memi,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [MEMI_W-1:0] host_memi,
  input  logic [31:0]       host_addr,
  input  logic [31:0]       host_wdata,
  output logic              host_ack,
  output logic              host_rvalid,
  output logic [31:0]       host_rdata,
  output logic              mem_we,
  output logic [MEMI_W-1:0] mem_memi,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_e  state_q, state_d;
  logic        grant_core, grant_host;
  logic        cnt_inc, cnt_clr, cnt_reached;
  logic        host_rvalid_q, host_rvalid_d;
  logic [31:0] host_rdata_q, host_rdata_d;

  dmem_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_i     (cnt_inc),
    .clr_i     (cnt_clr),
    .reached_o (cnt_reached)
  );

  // Grant decision and next state; reset overrides everything so no write
  // and no ack can escape while rst_n is low.
  always_comb begin
    state_d    = state_q;
    grant_core = 1'b0;
    grant_host = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    core_stall = 1'b0;
    case (state_q)
      ST_FORCE: begin
        // Host slot; if the host withdrew, the slot goes unused.
        grant_host = host_req;
        core_stall = host_req & core_req;
        cnt_clr    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        if (core_req) begin
          grant_core = 1'b1;
          if (host_req) begin
            cnt_inc = 1'b1;
            state_d = cnt_reached ? ST_FORCE : ST_WAIT;
          end else begin
            cnt_clr = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          grant_host = host_req;
          cnt_clr    = 1'b1;
          state_d    = ST_IDLE;
        end
      end
    endcase
    if (!rst_n) begin
      grant_core = 1'b0;
      grant_host = 1'b0;
      core_stall = 1'b0;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b1;
      state_d    = ST_IDLE;
    end
  end

  // Memory port mux and host read capture.
  always_comb begin
    mem_we        = grant_host ? host_we    : (grant_core & core_we);
    mem_memi      = grant_host ? host_memi  : core_memi;
    mem_addr      = grant_host ? host_addr  : core_addr;
    mem_wdata     = grant_host ? host_wdata : core_wdata;
    host_rvalid_d = grant_host & ~host_we;
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
  end

  assign host_ack    = grant_host;
  assign core_rdata  = mem_rdata;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

  // State and host read-return registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a small memory behind it.
module tb_dmem_arbiter;
  import rv32_arb_pkg::*;

  localparam int MW = 4;

  logic        clk;
  logic        rst_n;
  logic        core_req, core_we, host_req, host_we;
  logic [2:0]  core_memi, host_memi, mem_memi;
  logic [31:0] core_addr, core_wdata, host_addr, host_wdata;
  logic [31:0] core_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_stall, host_ack, host_rvalid, mem_we;

  dmem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_memi(core_memi),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_memi(host_memi),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_we(mem_we), .mem_memi(mem_memi), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory seen by the DUT: combinational read, write on clock edge.
  logic [31:0] mem [0:15];
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit [1:0]    grant;   // 0 none, 1 core, 2 host
    bit          ack, stall, we, rvalid;
    logic [2:0]  memi;
    logic [31:0] addr, wdata, rdata, crdata;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [31:0] ref_mem [0:15];
  int          denied     = 0;
  bit          force_pend = 1'b0;
  bit          rv_reg     = 1'b0;
  logic [31:0] rd_reg     = '0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Drive one cycle, predict the response, then advance past the clock edge.
  task automatic cycle(input bit rn, input bit creq, input bit cwe,
                       input logic [31:0] caddr, input logic [31:0] cwd,
                       input bit hreq, input bit hwe,
                       input logic [31:0] haddr, input logic [31:0] hwd);
    exp_t        e;
    bit          rv_n;
    logic [31:0] rd_n;
    logic [2:0]  cm, hm;
    cm = 3'($urandom);
    hm = 3'($urandom);
    rst_n = rn; core_req = creq; core_we = cwe; core_memi = cm;
    core_addr = caddr; core_wdata = cwd;
    host_req = hreq; host_we = hwe; host_memi = hm;
    host_addr = haddr; host_wdata = hwd;

    e = '{default: '0};
    e.rvalid = rv_reg;
    e.rdata  = rd_reg;
    if (!rn) begin
      denied = 0; force_pend = 1'b0;
    end else if (force_pend) begin
      if (hreq) e.grant = 2;
      e.stall = creq && hreq;
      denied = 0; force_pend = 1'b0;
    end else if (creq) begin
      e.grant = 1;
      if (hreq) begin
        denied++;
        if (denied >= MW) force_pend = 1'b1;
      end else begin
        denied = 0;
      end
    end else begin
      if (hreq) e.grant = 2;
      denied = 0;
    end

    if (e.grant == 1) begin
      e.we = cwe; e.addr = caddr; e.wdata = cwd; e.memi = cm;
      e.crdata = ref_mem[caddr[5:2]];
    end else if (e.grant == 2) begin
      e.we = hwe; e.addr = haddr; e.wdata = hwd; e.memi = hm;
    end
    e.ack = (e.grant == 2);

    if (!rn) begin
      rv_n = 1'b0; rd_n = '0;
    end else begin
      rv_n = (e.grant == 2) && !hwe;
      rd_n = rv_n ? ref_mem[haddr[5:2]] : rd_reg;
    end
    if (e.we) ref_mem[e.addr[5:2]] = e.wdata;
    sbq.push_back(e);
    rv_reg = rv_n;
    rd_reg = rd_n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input bit rn);
    cycle(rn, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_idle(string nm);
    check({nm, "_state"}, 32'(dut.state_q), 32'(ST_IDLE));
    check({nm, "_cnt"}, 32'(dut.u_cnt.cnt_q), 32'h0);
  endtask

  // Monitor: compares each cycle's presented outputs to the scoreboard head.
  initial begin
    exp_t m;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        m = sbq.pop_front();
        check("mem_we", 32'(mem_we), 32'(m.we));
        check("host_ack", 32'(host_ack), 32'(m.ack));
        check("core_stall", 32'(core_stall), 32'(m.stall));
        check("host_rvalid", 32'(host_rvalid), 32'(m.rvalid));
        check("host_rdata", host_rdata, m.rdata);
        if (m.grant != 0) begin
          check("mem_addr", mem_addr, m.addr);
          check("mem_wdata", mem_wdata, m.wdata);
          check("mem_memi", 32'(mem_memi), 32'(m.memi));
        end
        if (m.grant == 1) check("core_rdata", core_rdata, m.crdata);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    // Reset
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    check_idle("reset");

    // Host write then host read of 0x10
    cycle(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF);
    cycle(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
    idle_cycle(1'b1);
    check("host_rd_deadbeef", host_rdata, 32'hDEADBEEF);

    // Continuous contention: period-5 pattern
    repeat (10) cycle(1, 1, 0, 32'h4, 32'h0, 1, 0, 32'h8, 32'h0);
    idle_cycle(1'b1);

    // Host withdraws after two contended cycles
    cycle(1, 1, 0, 32'h4, 32'h0, 1, 1, 32'h8, 32'h55);
    cycle(1, 1, 0, 32'h4, 32'h0, 1, 1, 32'h8, 32'h55);
    cycle(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    check_idle("withdraw");

    // Core and forced host store to the same address
    repeat (4) cycle(1, 1, 0, 32'h20, 32'h0, 1, 1, 32'h20, 32'hAAAA0000);
    cycle(1, 1, 1, 32'h20, 32'h12345678, 1, 1, 32'h20, 32'hAAAA0000);
    check("force_host_store", mem[8], 32'hAAAA0000);
    cycle(1, 1, 1, 32'h20, 32'h12345678, 0, 0, 32'h0, 32'h0);
    check("core_store_last", mem[8], 32'h12345678);

    // Reset asserted in the FORCE cycle
    repeat (4) cycle(1, 1, 0, 32'h30, 32'h0, 1, 1, 32'h34, 32'hBAD0BAD0);
    cycle(0, 1, 1, 32'h30, 32'h77, 1, 1, 32'h34, 32'hBAD0BAD0);
    check_idle("rst_force");
    check("rst_force_mem", mem[13], 32'h0);
    idle_cycle(1'b1);
    check_idle("rst_release");

    // Randomized traffic
    repeat (600) begin
      bit rn, creq, hreq;
      rn   = ($urandom_range(0, 59) != 0);
      creq = ($urandom_range(0, 3) != 0);
      hreq = ($urandom_range(0, 4) >= 2);
      cycle(rn, creq, 1'($urandom), $urandom, $urandom,
            hreq, 1'($urandom), $urandom, $urandom);
    end
    idle_cycle(1'b1);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
